wb_accel_dispatch: RTL and testbench

- Writeback stage directly downstream of the MEM/WB pipeline register in the RV64 core.
- Selects and extends the register-file write data.
- Routes the NTT, PWAM and Keccak write strobes.
- Launches accelerator jobs and stalls the pipeline (holds MEM/WB and all upstream stages) until the launched accelerator reports done or times out.

---
 rtl/wb_accel_dispatch_pkg.sv | 53 +++++
 rtl/wb_load_ext.sv | 31 +++
 rtl/wb_accel_dispatch.sv | 183 ++++++++++++++++++
 tb/tb_wb_accel_dispatch.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_accel_dispatch_pkg.sv
// Shared widths, code points and types for the writeback / accelerator dispatch block.
package wb_accel_dispatch_pkg;

    localparam int unsigned XLEN = 64;

    // funct3 load size codes
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_D  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;
    localparam logic [2:0] SZ_WU = 3'b110;

    // data_to_reg source codes
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;
    localparam logic [1:0] WB_ZERO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_NTT    = 2'd0,
        SEL_PWAM   = 2'd1,
        SEL_KECCAK = 2'd2
    } sel_e;

    // One bit per accelerator, used for launch pulses
    typedef struct packed {
        logic ntt;
        logic pwam;
        logic keccak;
    } acc_vec_t;

    // One-hot launch vector for a given selection
    function automatic acc_vec_t sel_onehot(input sel_e s);
        acc_vec_t v;
        v = '0;
        case (s)
            SEL_NTT:    v.ntt    = 1'b1;
            SEL_PWAM:   v.pwam   = 1'b1;
            SEL_KECCAK: v.keccak = 1'b1;
            default:    v        = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Load data alignment: shift the addressed lane down, then sign/zero extend by size.
module wb_load_ext
    import wb_accel_dispatch_pkg::*;
(
    input  logic [XLEN-1:0] raw_i,
    input  logic [2:0]      addr_i,
    input  logic [2:0]      size_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] lane;

    // Misaligned accesses simply use whatever the shift produces
    assign lane = raw_i >> {addr_i, 3'b000};

    // Extension by access size; the unused code 111 yields zero
    always_comb begin
        data_o = '0;
        case (size_i)
            SZ_B:    data_o = {{(XLEN-8){lane[7]}},   lane[7:0]};
            SZ_H:    data_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
            SZ_W:    data_o = {{(XLEN-32){lane[31]}}, lane[31:0]};
            SZ_D:    data_o = lane;
            SZ_BU:   data_o = {{(XLEN-8){1'b0}},  lane[7:0]};
            SZ_HU:   data_o = {{(XLEN-16){1'b0}}, lane[15:0]};
            SZ_WU:   data_o = {{(XLEN-32){1'b0}}, lane[31:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/wb_accel_dispatch.sv
// Writeback stage: register-file write path, accelerator strobe gating and
// job launch / wait sequencing that stalls the pipeline while a job runs.
module wb_accel_dispatch
    import wb_accel_dispatch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_in,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] wb_data,
    input  logic [1:0]      data_to_reg,
    input  logic            reg_write,
    input  logic [2:0]      size,
    input  logic [XLEN-1:0] dmem_addr,
    input  logic            ntt_start,
    input  logic            pwam_start,
    input  logic            keccak_start,
    input  logic            ntt_we,
    input  logic            pwam_wea,
    input  logic            pwam_web,
    input  logic            keccak_we,
    input  logic            ntt_done,
    input  logic            pwam_done,
    input  logic            keccak_done,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            ntt_wr,
    output logic            pwam_wr_a,
    output logic            pwam_wr_b,
    output logic            keccak_wr,
    output logic [XLEN-1:0] acc_addr,
    output logic [XLEN-1:0] acc_wdata,
    output logic            ntt_go,
    output logic            pwam_go,
    output logic            keccak_go,
    output logic            stall,
    output logic            acc_err,
    output logic            acc_timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    sel_e             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    acc_vec_t         go_q, go_d;
    logic             err_q, err_d;
    logic             to_q, to_d;

    logic             any_start;
    logic             multi_start;
    sel_e             prio_sel;
    logic             sel_done;
    logic             idle;
    logic [XLEN-1:0]  load_data;
    logic             unused_inst;

    assign any_start   = ntt_start | pwam_start | keccak_start;
    assign multi_start = (ntt_start & pwam_start) | (ntt_start & keccak_start)
                       | (pwam_start & keccak_start);
    assign prio_sel    = ntt_start ? SEL_NTT : (pwam_start ? SEL_PWAM : SEL_KECCAK);
    assign idle        = (state_q == ST_IDLE);

    // Only the selected accelerator's done counts
    always_comb begin
        sel_done = 1'b0;
        case (sel_q)
            SEL_NTT:    sel_done = ntt_done;
            SEL_PWAM:   sel_done = pwam_done;
            SEL_KECCAK: sel_done = keccak_done;
            default:    sel_done = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (any_start) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = sel_done ? ST_IDLE : ST_WAIT;
            ST_WAIT:   if (sel_done || (cnt_q == CNT_LAST)) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of selection, timeout counter, launch pulses and sticky flags
    always_comb begin
        sel_d = sel_q;
        cnt_d = cnt_q;
        go_d  = '0;
        err_d = err_q;
        to_d  = to_q;
        case (state_q)
            ST_IDLE: begin
                if (any_start) begin
                    sel_d = prio_sel;
                    go_d  = sel_onehot(prio_sel);
                    if (multi_start) err_d = 1'b1;
                end
            end
            ST_LAUNCH: cnt_d = '0;
            ST_WAIT: begin
                if (!sel_done) begin
                    if (cnt_q == CNT_LAST) begin
                        to_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= SEL_NTT;
            cnt_q <= '0;
            go_q  <= '0;
            err_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            sel_q <= sel_d;
            cnt_q <= cnt_d;
            go_q  <= go_d;
            err_q <= err_d;
            to_q  <= to_d;
        end
    end

    wb_load_ext u_load_ext (
        .raw_i  (wb_data),
        .addr_i (dmem_addr[2:0]),
        .size_i (size),
        .data_o (load_data)
    );

    // Register-file write data source
    always_comb begin
        rf_wdata = '0;
        case (data_to_reg)
            WB_ALU:  rf_wdata = alu_out;
            WB_MEM:  rf_wdata = load_data;
            WB_LINK: rf_wdata = alu_out;
            WB_ZERO: rf_wdata = '0;
            default: rf_wdata = '0;
        endcase
    end

    assign rf_waddr    = inst_in[11:7];
    assign rf_we       = reg_write & (inst_in[11:7] != 5'd0) & idle & ~any_start;
    assign unused_inst = ^{inst_in[31:12], inst_in[6:0]};

    assign ntt_wr    = ntt_we    & idle;
    assign pwam_wr_a = pwam_wea  & idle;
    assign pwam_wr_b = pwam_web  & idle;
    assign keccak_wr = keccak_we & idle;

    assign acc_addr  = dmem_addr;
    assign acc_wdata = wb_data;

    assign ntt_go      = go_q.ntt;
    assign pwam_go     = go_q.pwam;
    assign keccak_go   = go_q.keccak;
    assign stall       = ~idle;
    assign acc_err     = err_q;
    assign acc_timeout = to_q;

endmodule

// File: tb/tb_wb_accel_dispatch.sv
// Randomized bench for wb_accel_dispatch against a job-level reference model.
module tb_wb_accel_dispatch;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_in;
    logic [63:0] alu_out, wb_data, dmem_addr;
    logic [1:0]  data_to_reg;
    logic        reg_write;
    logic [2:0]  size;
    logic        ntt_start, pwam_start, keccak_start;
    logic        ntt_we, pwam_wea, pwam_web, keccak_we;
    logic        ntt_done, pwam_done, keccak_done;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata, acc_addr, acc_wdata;
    logic        ntt_wr, pwam_wr_a, pwam_wr_b, keccak_wr;
    logic        ntt_go, pwam_go, keccak_go;
    logic        stall, acc_err, acc_timeout;

    always #5 clk = ~clk;

    wb_accel_dispatch #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .alu_out(alu_out), .wb_data(wb_data),
        .data_to_reg(data_to_reg), .reg_write(reg_write), .size(size), .dmem_addr(dmem_addr),
        .ntt_start(ntt_start), .pwam_start(pwam_start), .keccak_start(keccak_start),
        .ntt_we(ntt_we), .pwam_wea(pwam_wea), .pwam_web(pwam_web), .keccak_we(keccak_we),
        .ntt_done(ntt_done), .pwam_done(pwam_done), .keccak_done(keccak_done),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ntt_wr(ntt_wr), .pwam_wr_a(pwam_wr_a), .pwam_wr_b(pwam_wr_b), .keccak_wr(keccak_wr),
        .acc_addr(acc_addr), .acc_wdata(acc_wdata),
        .ntt_go(ntt_go), .pwam_go(pwam_go), .keccak_go(keccak_go),
        .stall(stall), .acc_err(acc_err), .acc_timeout(acc_timeout)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: job in flight, which accelerator, cycles since launch
    bit m_valid = 1'b0;
    bit m_busy, m_err, m_to;
    int m_sel, m_age;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] w, input logic [2:0] a,
                                             input logic [2:0] sz);
        logic [63:0] lane, mask, v;
        int          bytes;
        bit          sgn;
        lane = w >> (8 * int'(a));
        case (sz)
            3'd0: begin bytes = 1; sgn = 1'b1; end
            3'd1: begin bytes = 2; sgn = 1'b1; end
            3'd2: begin bytes = 4; sgn = 1'b1; end
            3'd3: begin bytes = 8; sgn = 1'b0; end
            3'd4: begin bytes = 1; sgn = 1'b0; end
            3'd5: begin bytes = 2; sgn = 1'b0; end
            3'd6: begin bytes = 4; sgn = 1'b0; end
            default: begin bytes = 0; sgn = 1'b0; end
        endcase
        if (bytes == 0) return 64'd0;
        if (bytes == 8) return lane;
        mask = (64'd1 << (8 * bytes)) - 64'd1;
        v = lane & mask;
        if (sgn && lane[8 * bytes - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic check_outputs();
        logic [2:0]  st;
        logic [63:0] exp_wd;
        logic [2:0]  exp_go;
        logic        exp_we;
        if (!m_valid) return;
        st = {ntt_start, pwam_start, keccak_start};
        case (data_to_reg)
            2'd1:    exp_wd = ref_load(wb_data, dmem_addr[2:0], size);
            2'd3:    exp_wd = 64'd0;
            default: exp_wd = alu_out;
        endcase
        exp_we = reg_write && (inst_in[11:7] != 5'd0) && !m_busy && (st == 3'b000);
        exp_go = (m_busy && m_age == 0) ? (3'b100 >> m_sel) : 3'b000;
        check_val("rf_we", 64'(rf_we), 64'(exp_we));
        check_val("rf_waddr", 64'(rf_waddr), 64'(inst_in[11:7]));
        check_val("rf_wdata", rf_wdata, exp_wd);
        check_val("strobes", 64'({ntt_wr, pwam_wr_a, pwam_wr_b, keccak_wr}),
                  m_busy ? 64'd0 : 64'({ntt_we, pwam_wea, pwam_web, keccak_we}));
        check_val("acc_addr", acc_addr, dmem_addr);
        check_val("acc_wdata", acc_wdata, wb_data);
        check_val("go", 64'({ntt_go, pwam_go, keccak_go}), 64'(exp_go));
        check_val("stall", 64'(stall), 64'(m_busy));
        check_val("acc_err", 64'(acc_err), 64'(m_err));
        check_val("acc_timeout", 64'(acc_timeout), 64'(m_to));
    endtask

    task automatic model_update();
        logic [2:0] st, dn;
        int         cnt;
        st = {ntt_start, pwam_start, keccak_start};
        dn = {ntt_done, pwam_done, keccak_done};
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_err   = 1'b0;
            m_to    = 1'b0;
            m_sel   = 0;
            m_age   = 0;
        end else if (!m_busy) begin
            if (st != 3'b000) begin
                cnt    = int'(st[0]) + int'(st[1]) + int'(st[2]);
                m_busy = 1'b1;
                m_sel  = st[2] ? 0 : (st[1] ? 1 : 2);
                m_age  = 0;
                if (cnt > 1) m_err = 1'b1;
            end
        end else if (dn[2 - m_sel]) begin
            m_busy = 1'b0;
        end else if (m_age == int'(T)) begin
            m_busy = 1'b0;
            m_to   = 1'b1;
        end else begin
            m_age++;
        end
    endtask

    // Inputs are set at negedge; check mid-cycle, advance model at posedge
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rst = 1'b0; inst_in = '0; alu_out = '0; wb_data = '0; dmem_addr = '0;
        data_to_reg = '0; reg_write = 1'b0; size = '0;
        ntt_start = 1'b0; pwam_start = 1'b0; keccak_start = 1'b0;
        ntt_we = 1'b0; pwam_wea = 1'b0; pwam_web = 1'b0; keccak_we = 1'b0;
        ntt_done = 1'b0; pwam_done = 1'b0; keccak_done = 1'b0;
    endtask

    task automatic randomize_inputs();
        inst_in     = $urandom;
        alu_out     = {$urandom, $urandom};
        wb_data     = {$urandom, $urandom};
        dmem_addr   = {$urandom, $urandom};
        data_to_reg = 2'($urandom_range(0, 3));
        reg_write   = 1'($urandom_range(0, 1));
        size        = 3'($urandom_range(0, 7));
        ntt_start    = ($urandom_range(0, 9) == 0);
        pwam_start   = ($urandom_range(0, 9) == 0);
        keccak_start = ($urandom_range(0, 9) == 0);
        ntt_we    = 1'($urandom_range(0, 1));
        pwam_wea  = 1'($urandom_range(0, 1));
        pwam_web  = 1'($urandom_range(0, 1));
        keccak_we = 1'($urandom_range(0, 1));
        ntt_done    = ($urandom_range(0, 5) == 0);
        pwam_done   = ($urandom_range(0, 5) == 0);
        keccak_done = ($urandom_range(0, 5) == 0);
        rst = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_val("reset_stall", 64'(stall), 64'd0);
        check_val("reset_flags", 64'({acc_err, acc_timeout}), 64'd0);
        tick();

        // LB sign / zero extension and rd=0 suppression
        size = 3'b000; dmem_addr = 64'd3; wb_data = 64'h0000_0000_80FF_0000;
        data_to_reg = 2'b01; inst_in = 32'(5 << 7); reg_write = 1'b1;
        #1;
        check_val("lb_we", 64'(rf_we), 64'd1);
        check_val("lb_waddr", 64'(rf_waddr), 64'd5);
        check_val("lb_sign", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        tick();
        size = 3'b100;
        #1;
        check_val("lbu_zero", rf_wdata, 64'h80);
        tick();
        inst_in = 32'd0;
        #1;
        check_val("rd0_we", 64'(rf_we), 64'd0);
        tick();

        // Simultaneous starts: ntt wins, error sticks; done coincident with launch
        clear_inputs();
        ntt_start = 1'b1; pwam_start = 1'b1; keccak_start = 1'b1;
        tick();
        clear_inputs();
        ntt_done = 1'b1;
        #1;
        check_val("multi_go", 64'({ntt_go, pwam_go, keccak_go}), 64'b100);
        check_val("multi_err", 64'(acc_err), 64'd1);
        tick();
        clear_inputs();
        #1;
        check_val("launch_done_stall", 64'(stall), 64'd0);
        tick();

        // Foreign done during a keccak wait is ignored
        keccak_start = 1'b1;
        tick();
        clear_inputs();
        tick();
        pwam_done = 1'b1;
        tick();
        clear_inputs();
        #1;
        check_val("foreign_done", 64'(stall), 64'd1);
        keccak_done = 1'b1;
        tick();
        clear_inputs();

        // Timeout: one launch cycle plus T wait cycles, then idle with flag set
        pwam_start = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i <= int'(T); i++) begin
            #1;
            check_val("to_stall", 64'(stall), 64'd1);
            tick();
        end
        #1;
        check_val("to_idle", 64'(stall), 64'd0);
        check_val("to_flag", 64'(acc_timeout), 64'd1);
        pwam_done = 1'b1;
        tick();
        clear_inputs();

        // Reset mid-wait aborts the job
        ntt_start = 1'b1;
        tick();
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
        tick();
        clear_inputs();
        pwam_wea = 1'b1;
        #1;
        check_val("rst_stall", 64'(stall), 64'd0);
        check_val("rst_flags", 64'({acc_err, acc_timeout}), 64'd0);
        check_val("rst_wr_a", 64'(pwam_wr_a), 64'd1);
        tick();
        ntt_done = 1'b1;
        tick();
        clear_inputs();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            randomize_inputs();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
